gap3d_cell_pipe: RTL



---
 rtl/gap3d_cell_pipe.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/gap3d_cell_pipe.sv
// Single-gap state cell for three-sequence affine-gap alignment.
// Computes Ix, Iy or Iz for one cell. The axis input selects which state is computed on each beat.
// The cell has three valid/ready pipeline stages:
//   S1 applies the saturating penalty subtraction.
//   S2 takes two partial maxima.
//   S3 takes the final maximum and drives the outputs.
module gap3d_cell_pipe #(
    parameter int unsigned W  = 12,
    parameter int unsigned G0 = 2,
    parameter int unsigned GE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_axis,
    input  logic signed [W-1:0] in_m,
    input  logic signed [W-1:0] in_ixy,
    input  logic signed [W-1:0] in_iyz,
    input  logic signed [W-1:0] in_ixz,
    input  logic signed [W-1:0] in_ix,
    input  logic signed [W-1:0] in_iy,
    input  logic signed [W-1:0] in_iz,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_score,
    output logic [2:0]          out_ptr,
    output logic [1:0]          out_axis,
    output logic                err_axis
);

    localparam logic signed [W-1:0] NEG_INF     = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] POS_MAX     = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] NEG_INF_EXT = {3'b111, {(W-1){1'b0}}};
    localparam logic signed [W+1:0] POS_MAX_EXT = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] P_OPEN2     = (W+2)'(2 * G0);
    localparam logic signed [W+1:0] P_MIX       = (W+2)'(G0 + GE);
    localparam logic signed [W+1:0] P_EXT2      = (W+2)'(2 * GE);
    localparam logic [1:0]          AXIS_BAD    = 2'd3;

    // Saturating subtract. A NEG_INF input acts as -infinity and stays NEG_INF.
    function automatic logic signed [W-1:0] sat_sub(input logic signed [W-1:0] x,
                                                    input logic signed [W+1:0] p);
        logic signed [W+1:0] d;
        d = {{2{x[W-1]}}, x} - p;
        if (x == NEG_INF)          sat_sub = NEG_INF;
        else if (d < NEG_INF_EXT)  sat_sub = NEG_INF;
        else if (d > POS_MAX_EXT)  sat_sub = POS_MAX;
        else                       sat_sub = d[W-1:0];
    endfunction

    // Stage valid/ready chain.
    logic r_v1, r_v2, r_v3;
    logic w_ld1, w_ld2, w_ld3;

    // Stage registers.
    logic signed [W-1:0] r_c1 [7];
    logic [1:0]          r_axis1, r_axis2;
    logic signed [W-1:0] r_lo_score, r_hi_score;
    logic [2:0]          r_lo_idx, r_hi_idx;
    logic signed [W-1:0] r_score;
    logic [2:0]          r_ptr;
    logic [1:0]          r_axis3;
    logic                r_err;

    // Combinational signals.
    logic signed [W-1:0] w_in   [7];
    logic signed [W+1:0] w_pen  [7];
    logic signed [W-1:0] w_cand [7];
    logic signed [W-1:0] w_lo_score, w_hi_score, w_a_score, w_b_score, w_fin_score;
    logic [2:0]          w_lo_idx, w_hi_idx, w_a_idx, w_b_idx, w_fin_idx;

    // Each stage loads when it is empty or its successor loads.
    always_comb begin
        w_ld3    = !r_v3 || out_ready;
        w_ld2    = !r_v2 || w_ld3;
        w_ld1    = !r_v1 || w_ld2;
        in_ready = w_ld1;
    end

    // Select the penalty for each candidate from the axis.
    // Candidate order: M, Ixy, Iyz, Ixz, Ix, Iy, Iz.
    always_comb begin
        w_in[0] = in_m;
        w_in[1] = in_ixy;
        w_in[2] = in_iyz;
        w_in[3] = in_ixz;
        w_in[4] = in_ix;
        w_in[5] = in_iy;
        w_in[6] = in_iz;
        for (int i = 0; i < 7; i++) w_pen[i] = P_MIX;
        w_pen[0] = P_OPEN2;
        case (in_axis)
            2'd0: begin w_pen[2] = P_OPEN2; w_pen[4] = P_EXT2; end
            2'd1: begin w_pen[3] = P_OPEN2; w_pen[5] = P_EXT2; end
            2'd2: begin w_pen[1] = P_OPEN2; w_pen[6] = P_EXT2; end
            default: ;
        endcase
        for (int i = 0; i < 7; i++) begin
            w_cand[i] = (in_axis == AXIS_BAD) ? NEG_INF : sat_sub(w_in[i], w_pen[i]);
        end
    end

    // S1: register the penalised candidates and the axis.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_axis1 <= 2'd0;
            for (int i = 0; i < 7; i++) r_c1[i] <= '0;
        end else if (w_ld1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_axis1 <= in_axis;
                for (int i = 0; i < 7; i++) r_c1[i] <= w_cand[i];
            end
        end
    end

    // Compute the partial maxima. The right operand replaces the left only when strictly greater,
    // so the lowest index wins a tie.
    always_comb begin
        w_a_score = r_c1[0];
        w_a_idx   = 3'd0;
        if (r_c1[1] > w_a_score) begin w_a_score = r_c1[1]; w_a_idx = 3'd1; end
        w_b_score = r_c1[2];
        w_b_idx   = 3'd2;
        if (r_c1[3] > w_b_score) begin w_b_score = r_c1[3]; w_b_idx = 3'd3; end
        w_lo_score = w_a_score;
        w_lo_idx   = w_a_idx;
        if (w_b_score > w_lo_score) begin w_lo_score = w_b_score; w_lo_idx = w_b_idx; end
        w_hi_score = r_c1[4];
        w_hi_idx   = 3'd4;
        if (r_c1[5] > w_hi_score) begin w_hi_score = r_c1[5]; w_hi_idx = 3'd5; end
        if (r_c1[6] > w_hi_score) begin w_hi_score = r_c1[6]; w_hi_idx = 3'd6; end
    end

    // S2: register both partial maxima.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v2       <= 1'b0;
            r_axis2    <= 2'd0;
            r_lo_score <= '0;
            r_lo_idx   <= 3'd0;
            r_hi_score <= '0;
            r_hi_idx   <= 3'd0;
        end else if (w_ld2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_axis2    <= r_axis1;
                r_lo_score <= w_lo_score;
                r_lo_idx   <= w_lo_idx;
                r_hi_score <= w_hi_score;
                r_hi_idx   <= w_hi_idx;
            end
        end
    end

    // Take the final maximum. An illegal axis reports pointer 7 with a -infinity score.
    always_comb begin
        w_fin_score = r_lo_score;
        w_fin_idx   = r_lo_idx;
        if (r_hi_score > w_fin_score) begin w_fin_score = r_hi_score; w_fin_idx = r_hi_idx; end
        if (r_axis2 == AXIS_BAD) begin
            w_fin_score = NEG_INF;
            w_fin_idx   = 3'd7;
        end
    end

    // S3: output register. It is held while out_valid is high and out_ready is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v3    <= 1'b0;
            r_score <= '0;
            r_ptr   <= 3'd0;
            r_axis3 <= 2'd0;
        end else if (w_ld3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_score <= w_fin_score;
                r_ptr   <= w_fin_idx;
                r_axis3 <= r_axis2;
            end
        end
    end

    // Sticky error flag. It is set when an illegal-axis beat is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (in_valid && w_ld1 && (in_axis == AXIS_BAD)) begin
            r_err <= 1'b1;
        end
    end

    assign out_valid = r_v3;
    assign out_score = r_score;
    assign out_ptr   = r_ptr;
    assign out_axis  = r_axis3;
    assign err_axis  = r_err;

endmodule
